mem_port_arbiter: RTL and testbench

Shares the single external memory port between instruction fetch and the memory-access stage. Arbitrates one access per cycle. Data accesses have default priority; a starvation counter guarantees fetch progress. Read responses from the one-cycle-latency synchronous memory are steered back to the requester that issued them. Sits between `instr_fetch`/`mem_access` and the top-level `o_mem_*` / `i_mem_rd_data` pins of `arriskv_top`.

---
 rtl/mem_port_arbiter_pkg.sv | 35 +++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 90 +++++++++
 tb/tb_mem_port_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: response owner and request bundle.
// Imported by the arbiter and its interface users.
package mem_port_arbiter_pkg;

  localparam int unsigned WD = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } mem_owner_t;

  typedef struct packed {
    logic          req;
    logic          we;
    logic [WD-1:0] addr;
    logic [WD-1:0] wdata;
  } mem_req_t;

  // Owner of the read response produced by this cycle's grant.
  function automatic mem_owner_t rd_owner(
    input logic if_gnt,
    input logic dm_rd_gnt
  );
    mem_owner_t o;
    o = OWN_NONE;
    unique case (1'b1)
      if_gnt:    o = OWN_IF;
      dm_rd_gnt: o = OWN_DM;
      default:   o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the arbiter.
// slave: arbiter side; master: requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int W = 32
);

  logic         i_if_req;
  logic [W-1:0] i_if_addr;
  logic         o_if_gnt;
  logic         o_if_rvalid;
  logic [W-1:0] o_if_rdata;

  logic         i_dm_req;
  logic         i_dm_we;
  logic [W-1:0] i_dm_addr;
  logic [W-1:0] i_dm_wdata;
  logic         o_dm_gnt;
  logic         o_dm_rvalid;
  logic [W-1:0] o_dm_rdata;

  logic [W-1:0] o_mem_rd_addr;
  logic [W-1:0] i_mem_rd_data;
  logic         o_mem_wr_en;
  logic [W-1:0] o_mem_wr_addr;
  logic [W-1:0] o_mem_wr_data;

  modport slave (
    input  i_if_req, i_if_addr,
    input  i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    input  i_mem_rd_data,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    output o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    output o_mem_rd_addr,
    output o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
  );

  modport master (
    output i_if_req, i_if_addr,
    output i_dm_req, i_dm_we, i_dm_addr, i_dm_wdata,
    output i_mem_rd_data,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    input  o_dm_gnt, o_dm_rvalid, o_dm_rdata,
    input  o_mem_rd_addr,
    input  o_mem_wr_en, o_mem_wr_addr, o_mem_wr_data
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch vs data onto one 1-cycle-latency memory port; steers reads.
// Ports: clk, rst_n (sync, active low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int wd_regs_p  = 32,
  parameter int max_wait_p = 4
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(max_wait_p + 1);
  localparam logic [CW-1:0] MAXW = CW'(max_wait_p);

  mem_owner_t           rsp_own_q, rsp_own_d;
  logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
  logic [wd_regs_p-1:0] rd_addr_q, rd_addr_d;

  logic if_gnt;
  logic dm_gnt;
  logic dm_rd;
  logic dm_wr;
  logic starve;

  always_comb begin
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    starve     = (wait_cnt_q == MAXW);
    // Data wins unless fetch has been denied long enough.
    if (rst_n) begin
      if (bus.i_if_req && (!bus.i_dm_req || starve)) begin
        if_gnt = 1'b1;
      end else if (bus.i_dm_req) begin
        dm_gnt = 1'b1;
      end
    end
    dm_rd      = dm_gnt && !bus.i_dm_we;
    dm_wr      = dm_gnt && bus.i_dm_we;

    rd_addr_d  = rd_addr_q;
    if (if_gnt) begin
      rd_addr_d = bus.i_if_addr;
    end else if (dm_rd) begin
      rd_addr_d = bus.i_dm_addr;
    end

    wait_cnt_d = wait_cnt_q;
    if (!bus.i_if_req || if_gnt) begin
      wait_cnt_d = '0;
    end else if (!starve) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    rsp_own_d  = rd_owner(if_gnt, dm_rd);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_own_q  <= OWN_NONE;
      wait_cnt_q <= '0;
      rd_addr_q  <= '0;
    end else begin
      rsp_own_q  <= rsp_own_d;
      wait_cnt_q <= wait_cnt_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  logic if_rv;
  logic dm_rv;

  assign if_rv = (rsp_own_q == OWN_IF);
  assign dm_rv = (rsp_own_q == OWN_DM);

  assign bus.o_if_gnt      = if_gnt;
  assign bus.o_dm_gnt      = dm_gnt;
  assign bus.o_if_rvalid   = if_rv;
  assign bus.o_dm_rvalid   = dm_rv;
  assign bus.o_if_rdata    = if_rv ? bus.i_mem_rd_data : '0;
  assign bus.o_dm_rdata    = dm_rv ? bus.i_mem_rd_data : '0;

  // Read address shows the new address in its grant cycle, else holds.
  assign bus.o_mem_rd_addr = rd_addr_d;
  assign bus.o_mem_wr_en   = dm_wr;
  assign bus.o_mem_wr_addr = dm_wr ? bus.i_dm_addr  : '0;
  assign bus.o_mem_wr_data = dm_wr ? bus.i_dm_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle synchronous memory model.
// Memory word at byte address a is preloaded with a + 0x100.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  mem_port_arbiter_if #(.W(32)) bus ();

  mem_port_arbiter #(
    .wd_regs_p (32),
    .max_wait_p(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [256];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 4) + 32'h100;
  end

  always @(posedge clk) begin
    if (bus.o_mem_wr_en) mem[bus.o_mem_wr_addr[9:2]] <= bus.o_mem_wr_data;
    bus.i_mem_rd_data <= mem[bus.o_mem_rd_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dd);
    @(negedge clk);
    bus.i_if_req   = ir;
    bus.i_if_addr  = ia;
    bus.i_dm_req   = dr;
    bus.i_dm_we    = dw;
    bus.i_dm_addr  = da;
    bus.i_dm_wdata = dd;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.i_if_req   = 1'b0;
    bus.i_if_addr  = '0;
    bus.i_dm_req   = 1'b0;
    bus.i_dm_we    = 1'b0;
    bus.i_dm_addr  = '0;
    bus.i_dm_wdata = '0;
    repeat (2) @(posedge clk);

    // Reset state
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_if_gnt", bus.o_if_gnt, 0);
    chk("rst_dm_gnt", bus.o_dm_gnt, 0);
    chk("rst_if_rvalid", bus.o_if_rvalid, 0);
    chk("rst_dm_rvalid", bus.o_dm_rvalid, 0);
    chk("rst_if_rdata", bus.o_if_rdata, 0);
    chk("rst_dm_rdata", bus.o_dm_rdata, 0);
    chk("rst_wr_en", bus.o_mem_wr_en, 0);
    chk("rst_rd_addr", bus.o_mem_rd_addr, 0);
    chk("rst_wr_addr", bus.o_mem_wr_addr, 0);
    chk("rst_wr_data", bus.o_mem_wr_data, 0);

    // IF-only stream
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ifs0_gnt", bus.o_if_gnt, 1);
    chk("ifs0_dm_gnt", bus.o_dm_gnt, 0);
    chk("ifs0_rvalid", bus.o_if_rvalid, 0);
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ifs1_gnt", bus.o_if_gnt, 1);
    chk("ifs1_rd_addr", bus.o_mem_rd_addr, 32'h4);
    chk("ifs1_rvalid", bus.o_if_rvalid, 1);
    chk("ifs1_rdata", bus.o_if_rdata, 32'h100);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("ifs2_gnt", bus.o_if_gnt, 1);
    chk("ifs2_rdata", bus.o_if_rdata, 32'h104);
    idle();
    chk("ifs3_rvalid", bus.o_if_rvalid, 1);
    chk("ifs3_rdata", bus.o_if_rdata, 32'h108);
    chk("ifs3_rd_hold", bus.o_mem_rd_addr, 32'h8);
    chk("ifs3_gnt", bus.o_if_gnt, 0);

    // Conflict: DM read wins, IF next cycle
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'h0);
    chk("cf0_dm_gnt", bus.o_dm_gnt, 1);
    chk("cf0_if_gnt", bus.o_if_gnt, 0);
    chk("cf0_rd_addr", bus.o_mem_rd_addr, 32'h200);
    chk("cf0_if_rvalid", bus.o_if_rvalid, 0);
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("cf1_if_gnt", bus.o_if_gnt, 1);
    chk("cf1_dm_rvalid", bus.o_dm_rvalid, 1);
    chk("cf1_dm_rdata", bus.o_dm_rdata, 32'h300);
    chk("cf1_if_rdata", bus.o_if_rdata, 0);
    idle();
    chk("cf2_if_rvalid", bus.o_if_rvalid, 1);
    chk("cf2_if_rdata", bus.o_if_rdata, 32'h110);

    // Starvation: IF held against continuous DM reads
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0);
      chk($sformatf("st%0d_dm_gnt", k), bus.o_dm_gnt, 1);
      chk($sformatf("st%0d_if_gnt", k), bus.o_if_gnt, 0);
    end
    drive(1'b1, 32'h30, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("st4_if_gnt", bus.o_if_gnt, 1);
    chk("st4_dm_gnt", bus.o_dm_gnt, 0);
    chk("st4_rd_addr", bus.o_mem_rd_addr, 32'h30);
    chk("st4_dm_rdata", bus.o_dm_rdata, 32'h120);
    drive(1'b1, 32'h34, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("st5_wait_cnt", 32'(dut.wait_cnt_q), 0);
    chk("st5_dm_gnt", bus.o_dm_gnt, 1);
    chk("st5_if_gnt", bus.o_if_gnt, 0);
    chk("st5_if_rdata", bus.o_if_rdata, 32'h130);
    idle();
    chk("st6_dm_rdata", bus.o_dm_rdata, 32'h120);

    // Write then IF read of same address
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
    chk("wr0_dm_gnt", bus.o_dm_gnt, 1);
    chk("wr0_wr_en", bus.o_mem_wr_en, 1);
    chk("wr0_wr_addr", bus.o_mem_wr_addr, 32'h40);
    chk("wr0_wr_data", bus.o_mem_wr_data, 32'hDEADBEEF);
    chk("wr0_rd_hold", bus.o_mem_rd_addr, 32'h20);
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr1_if_gnt", bus.o_if_gnt, 1);
    chk("wr1_wr_en", bus.o_mem_wr_en, 0);
    chk("wr1_dm_rvalid", bus.o_dm_rvalid, 0);
    chk("wr1_wr_addr", bus.o_mem_wr_addr, 0);
    idle();
    chk("wr2_if_rvalid", bus.o_if_rvalid, 1);
    chk("wr2_if_rdata", bus.o_if_rdata, 32'hDEADBEEF);
    chk("wr2_dm_rvalid", bus.o_dm_rvalid, 0);

    // Alternating owners DM, IF, DM
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0);
    chk("al0_dm_gnt", bus.o_dm_gnt, 1);
    drive(1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("al1_if_gnt", bus.o_if_gnt, 1);
    chk("al1_dm_rvalid", bus.o_dm_rvalid, 1);
    chk("al1_dm_rdata", bus.o_dm_rdata, 32'h144);
    chk("al1_if_rdata", bus.o_if_rdata, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h4C, 32'h0);
    chk("al2_dm_gnt", bus.o_dm_gnt, 1);
    chk("al2_if_rvalid", bus.o_if_rvalid, 1);
    chk("al2_if_rdata", bus.o_if_rdata, 32'h148);
    chk("al2_dm_rdata", bus.o_dm_rdata, 0);
    idle();
    chk("al3_dm_rvalid", bus.o_dm_rvalid, 1);
    chk("al3_dm_rdata", bus.o_dm_rdata, 32'h14C);
    chk("al3_if_rvalid", bus.o_if_rvalid, 0);

    // Reset mid-read: rst_n low at the edge ending the grant cycle
    drive(1'b1, 32'h50, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rr0_if_gnt", bus.o_if_gnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr0_gnt_forced", bus.o_if_gnt, 0);
    chk("rr0_wr_forced", bus.o_mem_wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.i_if_req = 1'b0;
    #1;
    chk("rr1_if_rvalid", bus.o_if_rvalid, 0);
    chk("rr1_if_rdata", bus.o_if_rdata, 0);
    chk("rr1_dm_rvalid", bus.o_dm_rvalid, 0);
    chk("rr1_if_gnt", bus.o_if_gnt, 0);
    chk("rr1_rd_addr", bus.o_mem_rd_addr, 0);
    chk("rr1_wr_en", bus.o_mem_wr_en, 0);
    idle();
    chk("rr2_if_rvalid", bus.o_if_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
